frame_source_arbiter: RTL

//  Frame-granular round-robin scheduler: shares the bit-serial input-FIFO port of the frame former among
//  NUM_SRC upstream source FIFOs. Looks like one FIFO read port (DATA/RE/EMPTY) to the frame former.

---
 rtl/frame_source_arbiter_pkg.sv | 25 ++
 rtl/frame_source_arbiter_rr_priority_picker.sv | 44 ++++
 rtl/frame_source_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/frame_source_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// frame_source_arbiter_pkg
//   Shared definitions for the frame source arbiter: FSM state encoding,
//   default parameter values and a width helper used to size index and
//   counter fields.
//   No ports (package).
// -----------------------------------------------------------------------------
package frame_source_arbiter_pkg;

  // Two-bit encoding leaves room for illegal codes, which the top module
  // detects and recovers from.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1
  } arb_state_e;

  localparam int unsigned NUM_SRC_DEFAULT     = 2;
  localparam int unsigned PAYLOAD_LEN_DEFAULT = 48;

  // Width needed to index n items; never returns zero.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_source_arbiter_rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
//   Purely combinational round-robin selector. Returns the first requesting
//   index at or after the pointer, scanning upward and wrapping from
//   NUM_SRC-1 to 0. NUM_SRC need not be a power of two.
// Ports
//   req_i      in   NUM_SRC  request vector
//   ptr_i      in   IDW      highest-priority index (must be < NUM_SRC)
//   idx_o      out  IDW      selected index (0 when nothing requests)
//   any_req_o  out  1        at least one request present
// -----------------------------------------------------------------------------
module rr_priority_picker
  import frame_source_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEFAULT,
  parameter int unsigned IDW     = idx_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [IDW-1:0]     idx_o,
  output logic               any_req_o
);

  // One extra bit so ptr + offset (at most 2*NUM_SRC-2) never overflows
  // before the explicit wrap.
  logic [IDW:0] cand;

  always_comb begin
    idx_o     = '0;
    any_req_o = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, ptr_i} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_SRC)) begin
        cand = cand - (IDW+1)'(NUM_SRC);
      end
      if (!any_req_o && req_i[cand[IDW-1:0]]) begin
        any_req_o = 1'b1;
        idx_o     = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/frame_source_arbiter.sv
// -----------------------------------------------------------------------------
// frame_source_arbiter
//   Frame-granular round-robin scheduler sharing the bit-serial input-FIFO
//   port of the frame former among NUM_SRC source FIFOs. Downstream it looks
//   like a single FIFO read port. The grant only moves after PAYLOAD_LEN bits
//   have been read, so every frame carries bits from exactly one source.
// Ports
//   CLK          in   1         clock, rising edge
//   RESET_N      in   1         synchronous reset, active low
//   SRC_DATA     in   NUM_SRC   source FIFO read data (1 cycle after SRC_RE)
//   SRC_RE       out  NUM_SRC   source FIFO read enables
//   SRC_EMPTY    in   NUM_SRC   source FIFO empty flags
//   SRC_EN       in   NUM_SRC   source enable mask, used only when arbitrating
//   FF_DATA      out  1         read data toward frame former
//   FF_RE        in   1         read enable from frame former
//   FF_EMPTY     out  1         empty flag toward frame former
//   GRANT_ID     out  IDW       currently granted source
//   GRANT_VALID  out  1         a grant is active
//   FRAME_DONE   out  1         pulse after the last bit of a grant is read
// -----------------------------------------------------------------------------
module frame_source_arbiter
  import frame_source_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_SRC     = NUM_SRC_DEFAULT,
  parameter  int unsigned PAYLOAD_LEN = PAYLOAD_LEN_DEFAULT,
  localparam int unsigned IDW         = idx_width(NUM_SRC),
  localparam int unsigned CW          = idx_width(PAYLOAD_LEN)
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [NUM_SRC-1:0] SRC_DATA,
  output logic [NUM_SRC-1:0] SRC_RE,
  input  logic [NUM_SRC-1:0] SRC_EMPTY,
  input  logic [NUM_SRC-1:0] SRC_EN,
  output logic               FF_DATA,
  input  logic               FF_RE,
  output logic               FF_EMPTY,
  output logic [IDW-1:0]     GRANT_ID,
  output logic               GRANT_VALID,
  output logic               FRAME_DONE
);

  localparam logic [CW-1:0]  LAST_CNT = CW'(PAYLOAD_LEN - 1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_SRC - 1);

  arb_state_e         state_q,       state_d;
  logic [IDW-1:0]     grant_id_q,    grant_id_d;
  logic               grant_valid_q, grant_valid_d;
  logic               frame_done_q,  frame_done_d;
  logic [IDW-1:0]     ptr_q,         ptr_d;
  logic [CW-1:0]      cnt_q,         cnt_d;
  logic [IDW-1:0]     data_sel_q,    data_sel_d;

  logic [NUM_SRC-1:0] eligible;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;
  logic               fwd;

  assign eligible = SRC_EN & ~SRC_EMPTY;

  rr_priority_picker #(
    .NUM_SRC (NUM_SRC),
    .IDW     (IDW)
  ) u_picker (
    .req_i     (eligible),
    .ptr_i     (ptr_q),
    .idx_o     (pick_idx),
    .any_req_o (pick_any)
  );

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    frame_done_d  = 1'b0;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    data_sel_d    = data_sel_q;
    SRC_RE        = '0;
    FF_EMPTY      = 1'b1;
    fwd           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_id_d    = pick_idx;
          grant_valid_d = 1'b1;
          state_d       = ST_GRANT;
        end
      end

      ST_GRANT: begin
        // A granted source that runs dry mid-frame simply stalls the port;
        // the grant is held until the frame's bit count is reached.
        FF_EMPTY           = SRC_EMPTY[grant_id_q];
        fwd                = FF_RE & ~FF_EMPTY;
        SRC_RE[grant_id_q] = fwd;
        if (fwd) begin
          data_sel_d = grant_id_q;
          if (cnt_q == LAST_CNT) begin
            cnt_d         = '0;
            ptr_d         = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
            grant_valid_d = 1'b0;
            frame_done_d  = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d       = ST_IDLE;
        grant_valid_d = 1'b0;
        cnt_d         = '0;
      end
    endcase

    // Reset is synchronous, so state_q may still read GRANT during the reset
    // cycle; keep the source FIFOs and the frame former quiet regardless.
    if (!RESET_N) begin
      SRC_RE   = '0;
      FF_EMPTY = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q       <= ST_IDLE;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      data_sel_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      frame_done_q  <= frame_done_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      data_sel_q    <= data_sel_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (RESET_N && (state_q != ST_IDLE) && (state_q != ST_GRANT)) begin
      $error("frame_source_arbiter: illegal state %0d", state_q);
    end
  end
`endif

  // data_sel lags the grant by one read, so the last bit of a frame still
  // comes from the old source after GRANT_VALID has dropped.
  assign FF_DATA     = SRC_DATA[data_sel_q];
  assign GRANT_ID    = grant_id_q;
  assign GRANT_VALID = grant_valid_q;
  assign FRAME_DONE  = frame_done_q;

endmodule
